// File: rtl/fifo_out.sv
// Output deskew buffer: delays lane k by (15-k) shifts so a diagonal wavefront lands aligned in row[0..15].
// Latency: lane k sample reaches row[k] after 16-k shifts; a read returns its word 1 cycle after command=11.
// Backpressure: none; each shift overwrites the row, so software reads a row before the next shift.
//
// Ports:
//   clk                clock, all state updates on its rising edge
//   resetn             asynchronous reset, ACTIVE HIGH despite the name
//   input0..input15    per-lane results from array lanes 0..15
//   command, col       10/11 = shift, 00/11 = flush, 11/c = read word c, anything else holds
//   output0            registered read word {row[4c+3], row[4c+2], row[4c+1], row[4c]}
//   row_valid          row register holds a complete wavefront
module fifo_out #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     input0,
    input  logic [DATA_W-1:0]     input1,
    input  logic [DATA_W-1:0]     input2,
    input  logic [DATA_W-1:0]     input3,
    input  logic [DATA_W-1:0]     input4,
    input  logic [DATA_W-1:0]     input5,
    input  logic [DATA_W-1:0]     input6,
    input  logic [DATA_W-1:0]     input7,
    input  logic [DATA_W-1:0]     input8,
    input  logic [DATA_W-1:0]     input9,
    input  logic [DATA_W-1:0]     input10,
    input  logic [DATA_W-1:0]     input11,
    input  logic [DATA_W-1:0]     input12,
    input  logic [DATA_W-1:0]     input13,
    input  logic [DATA_W-1:0]     input14,
    input  logic [DATA_W-1:0]     input15,
    input  logic [1:0]            command,
    input  logic [1:0]            col,
    output logic [4*DATA_W-1:0]   output0,
    output logic                  row_valid
);

    localparam int LANES = 16;

    logic [DATA_W-1:0] lane_in [LANES];
    logic [DATA_W-1:0] tail    [LANES];
    logic [DATA_W-1:0] row     [LANES];
    logic [4:0]        cnt;
    logic [4:0]        cnt_next;

    logic shift_en;
    logic flush_en;
    logic rd_en;

    assign lane_in[0]  = input0;
    assign lane_in[1]  = input1;
    assign lane_in[2]  = input2;
    assign lane_in[3]  = input3;
    assign lane_in[4]  = input4;
    assign lane_in[5]  = input5;
    assign lane_in[6]  = input6;
    assign lane_in[7]  = input7;
    assign lane_in[8]  = input8;
    assign lane_in[9]  = input9;
    assign lane_in[10] = input10;
    assign lane_in[11] = input11;
    assign lane_in[12] = input12;
    assign lane_in[13] = input13;
    assign lane_in[14] = input14;
    assign lane_in[15] = input15;

    // command is a single code, so these three can never be active together.
    assign shift_en = (command == 2'b10) && (col == 2'b11);
    assign flush_en = (command == 2'b00) && (col == 2'b11);
    assign rd_en    = (command == 2'b11);

    // Per-lane delay chains. Lane 15 has no stages and feeds the row directly.
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            if (k == LANES - 1) begin : g_direct
                assign tail[k] = lane_in[k];
            end else begin : g_chain
                localparam int DEPTH = LANES - 1 - k;
                logic [DATA_W-1:0] stage [DEPTH];

                always_ff @(posedge clk or posedge resetn) begin
                    if (resetn) begin
                        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                    end else if (flush_en) begin
                        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                    end else if (shift_en) begin
                        stage[0] <= lane_in[k];
                        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                    end
                end

                assign tail[k] = stage[DEPTH-1];
            end
        end
    endgenerate

    // Aligned row register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < LANES; i++) row[i] <= '0;
        end else if (flush_en) begin
            for (int i = 0; i < LANES; i++) row[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < LANES; i++) row[i] <= tail[i];
        end
    end

    // Fill counter saturates at 16; row_valid is registered alongside it so
    // it rises on the same edge as the 16th shift.
    assign cnt_next = (cnt == 5'd16) ? cnt : cnt + 5'd1;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cnt       <= '0;
            row_valid <= 1'b0;
        end else if (flush_en) begin
            cnt       <= '0;
            row_valid <= 1'b0;
        end else if (shift_en) begin
            cnt       <= cnt_next;
            row_valid <= (cnt_next == 5'd16);
        end
    end

    // Read word: lane 4c in the least significant byte. Flush leaves output0 alone.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            output0 <= '0;
        end else if (rd_en) begin
            output0 <= {row[{col, 2'b11}], row[{col, 2'b10}],
                        row[{col, 2'b01}], row[{col, 2'b00}]};
        end
    end

endmodule

// File: tb/tb_fifo_out.sv
module tb_fifo_out;

    logic        clk;
    logic        resetn;
    logic [7:0]  lanes [16];
    logic [1:0]  command;
    logic [1:0]  col;
    logic [31:0] output0;
    logic        row_valid;

    int checks = 0;
    int fails  = 0;

    fifo_out #(.DATA_W(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .input0   (lanes[0]),
        .input1   (lanes[1]),
        .input2   (lanes[2]),
        .input3   (lanes[3]),
        .input4   (lanes[4]),
        .input5   (lanes[5]),
        .input6   (lanes[6]),
        .input7   (lanes[7]),
        .input8   (lanes[8]),
        .input9   (lanes[9]),
        .input10  (lanes[10]),
        .input11  (lanes[11]),
        .input12  (lanes[12]),
        .input13  (lanes[13]),
        .input14  (lanes[14]),
        .input15  (lanes[15]),
        .command  (command),
        .col      (col),
        .output0  (output0),
        .row_valid(row_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one command for one rising edge, then park on a no-op code.
    task automatic do_cmd(input logic [1:0] c, input logic [1:0] q);
        command = c;
        col     = q;
        @(posedge clk);
        #1;
        command = 2'b01;
        col     = 2'b00;
    endtask

    // Wavefront pattern: lane k carries base+k only at shift index k.
    task automatic set_wave(input logic [7:0] base, input int s);
        for (int k = 0; k < 16; k++)
            lanes[k] = (s == k) ? base + 8'(k) : 8'h00;
    endtask

    task automatic set_all(input logic [7:0] base);
        for (int k = 0; k < 16; k++) lanes[k] = base + 8'(k);
    endtask

    task automatic read_check(input string tag, input logic [1:0] c, input logic [31:0] exp);
        do_cmd(2'b11, c);
        check(tag, output0, exp);
    endtask

    initial begin
        resetn  = 1'b1;
        command = 2'b01;
        col     = 2'b00;
        set_all(8'h00);
        #2;
        check("reset_output0", output0, 32'h0);
        check("reset_row_valid", {31'b0, row_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);

        // Wavefront A with no-ops and unqualified shifts interleaved.
        for (int s = 0; s < 16; s++) begin
            set_wave(8'hA0, s);
            do_cmd(2'b10, 2'b11);
            if (s == 4) begin
                // cnt is 5 here; these must not advance anything.
                set_all(8'h77);
                do_cmd(2'b10, 2'b00);
                do_cmd(2'b10, 2'b01);
                do_cmd(2'b10, 2'b10);
                do_cmd(2'b01, 2'b11);
                do_cmd(2'b00, 2'b00);
                do_cmd(2'b01, 2'b10);
            end
            if (s == 14) check("valid_after_15_shifts", {31'b0, row_valid}, 32'h0);
        end
        check("valid_after_16_shifts", {31'b0, row_valid}, 32'h1);

        read_check("wave_a_col0", 2'd0, 32'hA3A2A1A0);
        read_check("wave_a_col1", 2'd1, 32'hA7A6A5A4);
        read_check("wave_a_col2", 2'd2, 32'hABAAA9A8);
        read_check("wave_a_col3", 2'd3, 32'hAFAEADAC);

        // Hold behaviour of no-op codes and repeated reads.
        read_check("hold_col2_a", 2'd2, 32'hABAAA9A8);
        do_cmd(2'b01, 2'b11);
        check("hold_after_cmd01", output0, 32'hABAAA9A8);
        do_cmd(2'b00, 2'b00);
        check("hold_after_cmd00", output0, 32'hABAAA9A8);
        do_cmd(2'b10, 2'b01);
        check("hold_after_bad_shift", output0, 32'hABAAA9A8);
        check("hold_valid", {31'b0, row_valid}, 32'h1);
        read_check("hold_col2_b", 2'd2, 32'hABAAA9A8);
        read_check("hold_col0", 2'd0, 32'hA3A2A1A0);

        // Streaming: wavefront B at shift indices 16..31.
        for (int s = 0; s < 16; s++) begin
            set_wave(8'hB0, s);
            do_cmd(2'b10, 2'b11);
            check($sformatf("stream_valid_%0d", 16 + s), {31'b0, row_valid}, 32'h1);
        end
        read_check("wave_b_col3", 2'd3, 32'hBFBEBDBC);
        read_check("wave_b_col0", 2'd0, 32'hB3B2B1B0);

        // Flush clears row/valid but leaves output0 alone.
        do_cmd(2'b00, 2'b11);
        check("flush_valid", {31'b0, row_valid}, 32'h0);
        check("flush_keeps_output0", output0, 32'hB3B2B1B0);
        read_check("flush_row_col1", 2'd1, 32'h0);

        // Flush mid-fill: junk in the chains must not leak into the next row.
        set_all(8'h50);
        for (int s = 0; s < 7; s++) do_cmd(2'b10, 2'b11);
        do_cmd(2'b00, 2'b11);
        check("midfill_flush_valid", {31'b0, row_valid}, 32'h0);
        for (int s = 0; s < 16; s++) begin
            set_wave(8'hC0, s);
            do_cmd(2'b10, 2'b11);
            if (s == 14) check("flush_valid_after_15", {31'b0, row_valid}, 32'h0);
        end
        check("flush_valid_after_16", {31'b0, row_valid}, 32'h1);
        read_check("wave_c_col0", 2'd0, 32'hC3C2C1C0);
        read_check("wave_c_col1", 2'd1, 32'hC7C6C5C4);
        read_check("wave_c_col2", 2'd2, 32'hCBCAC9C8);
        read_check("wave_c_col3", 2'd3, 32'hCFCECDCC);

        // Asynchronous reset mid-run, between clock edges.
        read_check("pre_reset_col1", 2'd1, 32'hC7C6C5C4);
        resetn = 1'b1;
        #2;
        check("async_reset_output0", output0, 32'h0);
        check("async_reset_valid", {31'b0, row_valid}, 32'h0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        read_check("post_reset_col0", 2'd0, 32'h0);
        read_check("post_reset_col1", 2'd1, 32'h0);
        read_check("post_reset_col2", 2'd2, 32'h0);
        read_check("post_reset_col3", 2'd3, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
